// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 800x600 mode timing and lock FSM encodings.
// The timing generator uses the same constants as its parameter defaults.
package vga_pkg;

    localparam int MODE_H_ACTIVE = 800;
    localparam int MODE_H_SYNC   = 128;
    localparam int MODE_H_BACK   = 88;
    localparam int MODE_H_TOTAL  = 1056;
    localparam int MODE_V_ACTIVE = 600;
    localparam int MODE_V_SYNC   = 4;
    localparam int MODE_V_BACK   = 23;
    localparam int MODE_V_TOTAL  = 628;

    localparam int DEFAULT_LOCK_FRAMES = 2;

    typedef logic [1:0] lock_state_t;

    localparam lock_state_t SEARCH = 2'd0;
    localparam lock_state_t VERIFY = 2'd1;
    localparam lock_state_t LOCKED = 2'd2;

endpackage

// File: rtl/vga_sync_meas.sv
// One sync channel: polarity normalisation, leading-edge detect, saturating
// position counter and period measurement with first-measurement discard.
module vga_sync_meas #(
    parameter int W           = 12,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_en,
    input  logic         step,
    input  logic         sync_raw,
    input  logic         inc,
    input  logic         rearm,
    output logic [W-1:0] cnt,
    output logic [W-1:0] len,
    output logic [W-1:0] meas,
    output logic         sync_edge,
    output logic         meas_valid
);

    logic sync_norm;
    logic smp;
    logic prev;
    logic first;

    assign sync_norm  = ACTIVE_HIGH ? sync_raw : ~sync_raw;
    assign sync_edge  = step & smp & ~prev;
    assign meas       = cnt + W'(1);
    assign meas_valid = sync_edge & ~first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp   <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
            len   <= '0;
            first <= 1'b1;
        end else begin
            if (pix_en)
                smp <= sync_norm;
            if (step) begin
                prev <= smp;
                if (sync_edge) begin
                    cnt <= '0;
                    len <= meas;
                end else if (inc && cnt != '1) begin
                    cnt <= cnt + W'(1);
                end
            end
            // The length register still updates on a discarded measurement.
            if (rearm)
                first <= 1'b1;
            else if (sync_edge)
                first <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA timing receiver: recovers pixel position, measures line/frame length,
// locks against the expected mode and emits a per-pixel valid stream.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE         = MODE_H_ACTIVE,
    parameter int H_SYNC           = MODE_H_SYNC,
    parameter int H_BACK           = MODE_H_BACK,
    parameter int H_TOTAL          = MODE_H_TOTAL,
    parameter int V_ACTIVE         = MODE_V_ACTIVE,
    parameter int V_SYNC           = MODE_V_SYNC,
    parameter int V_BACK           = MODE_V_BACK,
    parameter int V_TOTAL          = MODE_V_TOTAL,
    parameter bit SYNC_ACTIVE_HIGH = 1'b1,
    parameter int LOCK_FRAMES      = DEFAULT_LOCK_FRAMES
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pix_en_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [3:0]  red_i,
    input  logic [3:0]  green_i,
    input  logic [3:0]  blue_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        pix_valid_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        err_o,
    output logic [11:0] h_total_o,
    output logic [10:0] v_total_o
);

    localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic        a_en;
    logic [11:0] a_rgb;
    logic        b_en;
    logic [11:0] b_rgb;

    logic [11:0] h_cnt;
    logic [11:0] h_meas;
    logic        h_edge;
    logic        h_meas_valid;
    logic [10:0] v_cnt;
    logic [10:0] v_meas;
    logic        v_edge;
    logic        v_meas_valid;

    lock_state_t state;
    logic [7:0]  good;
    logic [7:0]  good_next;
    logic        frame_bad;
    logic        sync_lost;
    logic        h_bad;
    logic        frame_ok;

    logic        in_window;
    logic [11:0] h_off;
    logic [10:0] v_off;

    // Stage A: input sample; the sync samples live inside the measurement units.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_en  <= 1'b0;
            a_rgb <= '0;
            b_en  <= 1'b0;
            b_rgb <= '0;
        end else begin
            a_en <= pix_en_i;
            if (pix_en_i)
                a_rgb <= {red_i, green_i, blue_i};
            b_en  <= a_en;
            b_rgb <= a_rgb;
        end
    end

    vga_sync_meas #(
        .W           (12),
        .ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
    ) u_hmeas (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .pix_en     (pix_en_i),
        .step       (a_en),
        .sync_raw   (hsync_i),
        .inc        (1'b1),
        .rearm      (sync_lost),
        .cnt        (h_cnt),
        .len        (h_total_o),
        .meas       (h_meas),
        .sync_edge  (h_edge),
        .meas_valid (h_meas_valid)
    );

    vga_sync_meas #(
        .W           (11),
        .ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
    ) u_vmeas (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .pix_en     (pix_en_i),
        .step       (a_en),
        .sync_raw   (vsync_i),
        .inc        (h_edge),
        .rearm      (sync_lost),
        .cnt        (v_cnt),
        .len        (v_total_o),
        .meas       (v_meas),
        .sync_edge  (v_edge),
        .meas_valid (v_meas_valid)
    );

    // An hsync edge arriving on the saturated count is a resync, not a loss.
    assign sync_lost = (h_cnt == '1) && !h_edge;
    assign h_bad     = h_meas_valid && (h_meas != 12'(H_TOTAL));
    assign frame_ok  = v_meas_valid && (v_meas == 11'(V_TOTAL)) && !frame_bad && !h_bad;
    assign good_next = good + 8'd1;
    assign locked_o  = (state == LOCKED);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= SEARCH;
            good      <= '0;
            frame_bad <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (sync_lost) begin
                state     <= SEARCH;
                good      <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (v_edge)
                    frame_bad <= 1'b0;
                else if (h_bad)
                    frame_bad <= 1'b1;
                case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state <= VERIFY;
                            good  <= '0;
                        end
                    end
                    VERIFY: begin
                        if (v_edge) begin
                            if (frame_ok) begin
                                good <= good_next;
                                if (good_next >= 8'(LOCK_FRAMES))
                                    state <= LOCKED;
                            end else begin
                                good <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (h_bad || (v_edge && !frame_ok)) begin
                            err_o <= 1'b1;
                            state <= VERIFY;
                            good  <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign in_window = (h_cnt >= H_START) && (h_cnt < H_END) &&
                       (v_cnt >= V_START) && (v_cnt < V_END);
    assign h_off     = h_cnt - H_START;
    assign v_off     = v_cnt - V_START;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_o           <= '0;
            y_o           <= '0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            pix_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            pix_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            if (b_en && in_window && state == LOCKED) begin
                pix_valid_o   <= 1'b1;
                frame_start_o <= (h_off == '0) && (v_off == '0);
                x_o           <= h_off[10:0];
                y_o           <= v_off;
                red_o         <= b_rgb[11:8];
                green_o       <= b_rgb[7:4];
                blue_o        <= b_rgb[3:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced mode, with active-high and
// active-low sync instances driven by the same pixel stream.
module tb_vga_capture;

    localparam int HA = 16;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HT = 26;
    localparam int VA = 6;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = 12;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        fs;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic       hs, vs, hs_n, vs_n;
    logic [3:0] red, green, blue;

    logic [10:0] x_o[2];
    logic [10:0] y_o[2];
    logic [3:0]  ro[2];
    logic [3:0]  go[2];
    logic [3:0]  bo[2];
    logic        pv[2];
    logic        fs[2];
    logic        lk[2];
    logic        er[2];
    logic [11:0] ht[2];
    logic [10:0] vt[2];

    pix_t q0[$];
    pix_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid[2];
    int   n_err[2];
    logic lk_prev[2];
    pix_t act, expv;

    assign hs_n = ~hs;
    assign vs_n = ~vs;

    always #5 clk = ~clk;

    vga_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(2)
    ) dut_pos (
        .clk_i(clk), .rst_n_i(rst_n), .pix_en_i(pix_en),
        .hsync_i(hs), .vsync_i(vs),
        .red_i(red), .green_i(green), .blue_i(blue),
        .x_o(x_o[0]), .y_o(y_o[0]),
        .red_o(ro[0]), .green_o(go[0]), .blue_o(bo[0]),
        .pix_valid_o(pv[0]), .frame_start_o(fs[0]), .locked_o(lk[0]),
        .err_o(er[0]), .h_total_o(ht[0]), .v_total_o(vt[0])
    );

    vga_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_ACTIVE_HIGH(1'b0), .LOCK_FRAMES(2)
    ) dut_neg (
        .clk_i(clk), .rst_n_i(rst_n), .pix_en_i(pix_en),
        .hsync_i(hs_n), .vsync_i(vs_n),
        .red_i(red), .green_i(green), .blue_i(blue),
        .x_o(x_o[1]), .y_o(y_o[1]),
        .red_o(ro[1]), .green_o(go[1]), .blue_o(bo[1]),
        .pix_valid_o(pv[1]), .frame_start_o(fs[1]), .locked_o(lk[1]),
        .err_o(er[1]), .h_total_o(ht[1]), .v_total_o(vt[1])
    );

    task automatic chk(input string name, input int d, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, got, want);
        end
    endtask

    // Monitor: pops one expectation per valid pulse, and ties err_o to the lock drop.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pv[d]) begin
                n_valid[d]++;
                act = {x_o[d], y_o[d], ro[d], go[d], bo[d], fs[d]};
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_valid", d, 64'(pv[d]), 64'd0);
                end else begin
                    if (d == 0) expv = q0.pop_front();
                    else        expv = q1.pop_front();
                    chk("pixel", d, 64'(act), 64'(expv));
                end
            end
            if (er[d]) begin
                n_err[d]++;
                chk("err_with_lock_drop", d, {62'd0, lk_prev[d], lk[d]}, 64'd2);
            end
            lk_prev[d] = lk[d];
        end
    end

    task automatic send_pix(input logic h, input logic v, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        @(negedge clk);
        pix_en = 1'b1;
        hs     = h;
        vs     = v;
        red    = r;
        green  = g;
        blue   = b;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        for (int d = 0; d < 2; d++)
            chk(name, d, {3'd0, x_o[d], y_o[d], ro[d], go[d], bo[d], pv[d], fs[d], lk[d], er[d], ht[d], vt[d]}, 64'd0);
    endtask

    task automatic do_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame of stimulus; short_line drops the last pixel of that line,
    // rst_line pulses reset right after pixel 12 of that line (x=5).
    task automatic send_frame(input bit lock, input int short_line, input int rst_line);
        bit   live;
        pix_t e;
        int   base0, base1;
        logic [3:0] rv, gv, bv;
        live  = lock;
        base0 = n_valid[0];
        base1 = n_valid[1];
        chk("queue_drained", 0, 64'(q0.size()), 64'd0);
        chk("queue_drained", 1, 64'(q1.size()), 64'd0);
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < HT; p++) begin
                if (!(l == short_line && p == HT - 1)) begin
                    if (short_line >= 0 && l == short_line + 1)
                        live = 1'b0;
                    rv = 4'(p);
                    gv = 4'(l);
                    bv = 4'(p + 3 * l);
                    if (live && l >= VS + VB && l < VS + VB + VA && p >= HS + HB && p < HS + HB + HA) begin
                        e.x  = 11'(p - (HS + HB));
                        e.y  = 11'(l - (VS + VB));
                        e.r  = rv;
                        e.g  = gv;
                        e.b  = bv;
                        e.fs = (p == HS + HB) && (l == VS + VB);
                        q0.push_back(e);
                        q1.push_back(e);
                    end
                    send_pix(p < HS, l < VS, rv, gv, bv);
                    if (l == 0 && p == 2) begin
                        for (int d = 0; d < 2; d++) begin
                            chk("locked_at_frame_start", d, 64'(lk[d]), 64'(lock));
                            if (lock) begin
                                chk("h_total", d, 64'(ht[d]), 64'd26);
                                chk("v_total", d, 64'(vt[d]), 64'd12);
                            end
                        end
                    end
                    if (short_line >= 0 && l == short_line + 1 && p == 2) begin
                        for (int d = 0; d < 2; d++) begin
                            chk("short_h_total", d, 64'(ht[d]), 64'd25);
                            chk("short_unlocked", d, 64'(lk[d]), 64'd0);
                            chk("short_err_count", d, 64'(n_err[d]), 64'd1);
                        end
                    end
                    if (l == rst_line && p == 12) begin
                        do_reset();
                        live = 1'b0;
                    end
                end
            end
        end
        if (lock && short_line < 0 && rst_line < 0) begin
            chk("frame_pulse_count", 0, 64'(n_valid[0] - base0), 64'd96);
            chk("frame_pulse_count", 1, 64'(n_valid[1] - base1), 64'd96);
        end
    endtask

    initial begin
        int base0, base1;
        n_valid = '{0, 0};
        n_err   = '{0, 0};
        lk_prev = '{1'b0, 1'b0};
        rst_n   = 1'b1;
        pix_en  = 1'b0;
        hs      = 1'b0;
        vs      = 1'b0;
        red     = '0;
        green   = '0;
        blue    = '0;
        #1 rst_n = 1'b0;
        #6 chk_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Acquisition: locked from the third vsync edge.
        send_frame(1'b0, -1, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b1, -1, -1);
        send_frame(1'b1, -1, -1);

        // Short line at y=1, then relock after two good frames.
        send_frame(1'b1, 5, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b1, -1, -1);

        // Sync loss: hsync inactive for 4096 strobes.
        base0 = n_valid[0];
        base1 = n_valid[1];
        repeat (4096) send_pix(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("sync_lost_unlocked", 0, 64'(lk[0]), 64'd0);
        chk("sync_lost_unlocked", 1, 64'(lk[1]), 64'd0);
        chk("sync_lost_no_valid", 0, 64'(n_valid[0] - base0), 64'd0);
        chk("sync_lost_no_valid", 1, 64'(n_valid[1] - base1), 64'd0);
        send_frame(1'b0, -1, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b1, -1, -1);

        // Reset mid active area, then the full acquisition sequence again.
        send_frame(1'b1, -1, 6);
        send_frame(1'b0, -1, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b1, -1, -1);

        repeat (4) @(negedge clk);
        chk("final_queue_drained", 0, 64'(q0.size()), 64'd0);
        chk("final_queue_drained", 1, 64'(q1.size()), 64'd0);
        chk("final_err_count", 0, 64'(n_err[0]), 64'd1);
        chk("final_err_count", 1, 64'(n_err[1]), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
